// File: rtl/audio_pkg.sv
// Shared types and widths for the ADC sample sequencer.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADC_W    = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    OUTPUT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, on the wrap of the count.
module rate_tick_gen #(
  parameter int DIV = 1041
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..DIV-1 and wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Scans the enabled ADC channels once per sample tick: settle the mux,
// run one conversion, hand the signed sample downstream, move to the next channel.
module adc_sample_sequencer
  import audio_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 48_000,
  parameter int NUM_CH      = 2,
  parameter int SETTLE_CYC  = 8,
  parameter int EOC_TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic [4:0]          adc_chsel,
  output logic                adc_soc,
  input  logic                adc_eoc,
  input  logic [ADC_W-1:0]    adc_dout,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic [2:0]          smp_ch,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic                overrun,
  output logic                timeout
);

  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_MAX  = (SETTLE_CYC > EOC_TIMEOUT) ? SETTLE_CYC : EOC_TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(EOC_TIMEOUT - 1);

  // Offset binary to two's complement, left-justified in the sample word.
  // Placing the 12-bit signed value in the top bits is the same as
  // sign-extending it and shifting left by the width difference.
  function automatic logic signed [SAMPLE_W-1:0] to_sample(input logic [ADC_W-1:0] raw);
    logic signed [ADC_W-1:0] centred;
    centred = signed'(raw ^ {1'b1, {(ADC_W-1){1'b0}}});
    return {centred, {(SAMPLE_W-ADC_W){1'b0}}};
  endfunction

  seq_state_e                  r_state;
  seq_state_e                  w_state_nxt;
  logic [NUM_CH-1:0]           r_frame_mask;
  logic [2:0]                  r_ch;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_timeout;
  logic signed [SAMPLE_W-1:0]  r_smp_data;
  logic [2:0]                  r_smp_ch;

  logic       w_tick;
  logic [2:0] w_first_ch;
  logic       w_first_vld;
  logic [2:0] w_next_ch;
  logic       w_next_vld;
  logic       w_ld_first;
  logic       w_ld_next;
  logic       w_cnt_clr;
  logic       w_capture;
  logic       w_to;
  logic       w_advance;

  rate_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Lowest enabled channel of the live mask, and next higher channel of the frame mask.
  always_comb begin
    w_first_ch = '0;
    w_next_ch  = '0;
    w_next_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_first_ch = 3'(i);
      end
      if (r_frame_mask[i] && (3'(i) > r_ch)) begin
        w_next_ch  = 3'(i);
        w_next_vld = 1'b1;
      end
    end
  end

  assign w_first_vld = |ch_mask;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore outputs; a tick outside IDLE is dropped and flagged.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_first  = 1'b0;
    w_ld_next   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_capture   = 1'b0;
    w_to        = 1'b0;
    w_advance   = 1'b0;
    adc_soc     = 1'b0;
    smp_valid   = 1'b0;
    overrun     = w_tick && (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_tick && w_first_vld) begin
          w_state_nxt = SETTLE;
          w_ld_first  = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = CONVERT;
          w_cnt_clr   = 1'b1;
        end
      end
      CONVERT: begin
        adc_soc = 1'b1;
        if (adc_eoc) begin
          w_state_nxt = OUTPUT;
          w_capture   = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_to      = 1'b1;
          w_advance = 1'b1;
        end
      end
      OUTPUT: begin
        smp_valid = 1'b1;
        if (smp_ready) begin
          w_advance = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_advance) begin
      if (w_next_vld) begin
        w_state_nxt = SETTLE;
        w_ld_next   = 1'b1;
        w_cnt_clr   = 1'b1;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  // Frame mask, current channel, shared settle/conversion counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_mask <= '0;
      r_ch         <= '0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_timeout <= w_to;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_ld_first) begin
        r_frame_mask <= ch_mask;
        r_ch         <= w_first_ch;
      end else if (w_ld_next) begin
        r_ch <= w_next_ch;
      end
    end
  end

  // Sample capture on end-of-conversion; held stable through OUTPUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp_data <= '0;
      r_smp_ch   <= '0;
    end else if (w_capture) begin
      r_smp_data <= to_sample(adc_dout);
      r_smp_ch   <= r_ch;
    end
  end

  assign adc_chsel = 5'(r_ch) + 5'd1;
  assign smp_data  = r_smp_data;
  assign smp_ch    = r_smp_ch;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer: an ADC model answers each
// conversion and queues the expected sample; a frame model queues the
// expected channel order at each tick; a monitor compares on handshakes.
`timescale 1ns/1ps
module tb_adc_sample_sequencer;

  localparam int NUM_CH   = 2;
  localparam int SETTLE   = 8;
  localparam int EOC_TO   = 256;
  localparam int TICK_DIV = 50_000_000 / 48_000;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic [NUM_CH-1:0] ch_mask   = '0;
  logic [4:0]        adc_chsel;
  logic              adc_soc;
  logic              adc_eoc   = 1'b0;
  logic [11:0]       adc_dout  = '0;
  logic [15:0]       smp_data;
  logic [2:0]        smp_ch;
  logic              smp_valid;
  logic              smp_ready = 1'b0;
  logic              overrun;
  logic              timeout;

  adc_sample_sequencer #(
    .CLK_HZ(50_000_000), .SAMPLE_HZ(48_000), .NUM_CH(NUM_CH),
    .SETTLE_CYC(SETTLE), .EOC_TIMEOUT(EOC_TO)
  ) dut (
    .clk(clk), .rst(rst), .ch_mask(ch_mask), .adc_chsel(adc_chsel),
    .adc_soc(adc_soc), .adc_eoc(adc_eoc), .adc_dout(adc_dout),
    .smp_data(smp_data), .smp_ch(smp_ch), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Cycles since reset release; the frame rate is one tick every TICK_DIV cycles.
  int   k = 0;
  logic tick_m;
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end
  assign tick_m = !rst && ((k % TICK_DIV) == TICK_DIV - 1);

  typedef struct { int ch; int val; } exp_t;
  exp_t        dq[$];
  int          chq[$];
  logic [11:0] dout_q[$];

  int eoc_mode   = 1;   // 0 never answer, 1 fixed delay, 2 random delay
  int eoc_dly    = 20;
  int ready_mode = 1;   // 0 stall, 1 always ready, 2 random
  int soc_age    = 0;
  int cur_dly    = 0;
  int hs_cnt = 0, ovr_cnt = 0, to_cnt = 0, soc_cnt = 0, vld_cnt = 0;

  // ADC model: end-of-conversion cur_dly cycles after start-of-conversion rises.
  always @(negedge clk) begin
    adc_eoc = 1'b0;
    if (rst || !adc_soc) begin
      soc_age = 0;
    end else begin
      if (soc_age == 0) cur_dly = (eoc_mode == 2) ? int'($urandom_range(0, 40)) : eoc_dly;
      if (eoc_mode != 0 && soc_age == cur_dly) begin
        adc_dout = (dout_q.size() != 0) ? dout_q.pop_front() : 12'($urandom);
        adc_eoc  = 1'b1;
        dq.push_back('{ch: int'(adc_chsel) - 1, val: (int'(adc_dout) - 2048) * 16});
      end
      soc_age++;
    end
  end

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic [2:0]  prev_ch    = '0;

  // Ready driver and monitor.
  always @(negedge clk) begin
    case (ready_mode)
      0:       smp_ready = 1'b0;
      1:       smp_ready = 1'b1;
      default: smp_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (rst) begin
      chq.delete();
      dq.delete();
      prev_stall = 1'b0;
    end else begin
      if (overrun)   ovr_cnt++;
      if (timeout)   to_cnt++;
      if (adc_soc)   soc_cnt++;
      if (smp_valid) vld_cnt++;
      if (prev_stall)
        check("hold_valid_ch_data", {smp_valid, smp_ch, smp_data}, {1'b1, prev_ch, prev_data});
      if (timeout) begin
        check("timeout_ch_pending", chq.size() > 0, 1);
        if (chq.size() > 0) chq.delete(0);
      end
      if (tick_m) begin
        check("overrun_at_tick", overrun, chq.size() != 0);
        if (chq.size() == 0)
          for (int i = 0; i < NUM_CH; i++) if (ch_mask[i]) chq.push_back(i);
      end else if (overrun) begin
        check("overrun_no_tick", overrun, 0);
      end
      if (smp_valid && smp_ready) begin
        hs_cnt++;
        check("sample_pending", (dq.size() != 0) && (chq.size() != 0), 1);
        if (dq.size() != 0 && chq.size() != 0) begin
          check("smp_ch", smp_ch, chq[0]);
          check("adc_chsel_order", dq[0].ch, chq[0]);
          check("smp_data", $signed(smp_data), dq[0].val);
          dq.delete(0);
          chq.delete(0);
        end
      end
      prev_stall = smp_valid && !smp_ready;
      prev_data  = smp_data;
      prev_ch    = smp_ch;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_chsel", adc_chsel, 1);
    check("rst_soc", adc_soc, 0);
    check("rst_valid", smp_valid, 0);
    check("rst_data", smp_data, 0);
    check("rst_ch", smp_ch, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    sync();
    rst = 1'b0;

    // Empty mask for five ticks: nothing happens
    soc_cnt = 0; vld_cnt = 0; ovr_cnt = 0;
    repeat (5 * TICK_DIV + 10) @(posedge clk);
    #1;
    check("zero_mask_soc", soc_cnt, 0);
    check("zero_mask_valid", vld_cnt, 0);
    check("zero_mask_overrun", ovr_cnt, 0);

    // Two channels, fixed 20-cycle conversion, corner codes
    sync();
    ch_mask = 2'b11; eoc_mode = 1; eoc_dly = 20; ready_mode = 1;
    hs_cnt = 0; ovr_cnt = 0;
    dout_q.push_back(12'hFFF); dout_q.push_back(12'h000);
    dout_q.push_back(12'h800); dout_q.push_back(12'h5A3);
    n = 0;
    do begin @(negedge clk); n++; end while (!tick_m && n < 2 * TICK_DIV);
    check("tick_seen", tick_m, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!smp_valid && n < 200);
    check("latency_tick_to_valid", n, SETTLE + 20 + 2);
    repeat (200) @(negedge clk);
    check("frame1_samples", hs_cnt, 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!tick_m && n < 2 * TICK_DIV);
    repeat (200) @(negedge clk);
    check("frame2_samples", hs_cnt, 4);
    check("frames_no_overrun", ovr_cnt, 0);

    // Downstream stall for 2000 cycles
    sync();
    ready_mode = 0; hs_cnt = 0; ovr_cnt = 0;
    dout_q.push_back(12'h7FF); dout_q.push_back(12'h801);
    n = 0;
    do begin @(negedge clk); n++; end while (!smp_valid && n < 2 * TICK_DIV);
    check("stall_valid_seen", smp_valid, 1);
    repeat (2000) @(negedge clk);
    check("stall_valid_held", smp_valid, 1);
    check("stall_overrun_once", ovr_cnt, 1);
    check("stall_no_handshake", hs_cnt, 0);
    sync();
    ready_mode = 1;
    repeat (40) @(negedge clk);
    check("stall_frame_done", hs_cnt, 2);

    // Conversion never ends on a single channel
    sync();
    eoc_mode = 0; ch_mask = 2'b01; to_cnt = 0; vld_cnt = 0; hs_cnt = 0; ovr_cnt = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_soc && n < 2 * TICK_DIV);
    check("to_soc_seen", adc_soc, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout && n < 400);
    check("to_latency", n, EOC_TO);
    @(negedge clk);
    check("to_pulse_count", to_cnt, 1);
    check("to_soc_low", adc_soc, 0);
    check("to_no_valid", vld_cnt, 0);
    sync();
    eoc_mode = 1;
    repeat (TICK_DIV + 100) @(negedge clk);
    check("to_next_frame", hs_cnt, 1);
    check("to_no_overrun", ovr_cnt, 0);

    // Reset during a conversion
    sync();
    eoc_mode = 0; ch_mask = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (!adc_soc && n < 2 * TICK_DIV);
    check("midrst_soc_seen", adc_soc, 1);
    sync();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_soc", adc_soc, 0);
    check("midrst_valid", smp_valid, 0);
    check("midrst_chsel", adc_chsel, 1);
    sync();
    rst = 1'b0; eoc_mode = 1; hs_cnt = 0; ovr_cnt = 0;
    repeat (TICK_DIV + 100) @(negedge clk);
    check("midrst_frame_after", hs_cnt, 2);
    check("midrst_no_overrun", ovr_cnt, 0);

    // Random masks (changed mid-frame too), conversion delays, data and ready
    sync();
    eoc_mode = 2; ready_mode = 2;
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(50, TICK_DIV)) @(posedge clk);
      #1;
      ch_mask = NUM_CH'($urandom);
    end
    sync();
    ch_mask = '0; ready_mode = 1;
    repeat (TICK_DIV + 200) @(negedge clk);
    check("drain_channels", chq.size(), 0);
    check("drain_samples", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
